// File: rtl/arb_req_frontend.sv
// arb_req_frontend: request conditioning in front of a three-client
// round-robin arbiter. Client request pulses are queued per client as
// saturating pending counts. A level request is held towards the arbiter
// while work is outstanding, and each grant cycle retires one request.
// Sticky flags report overflow, spurious grants and (optionally) starvation.
// Optional feature macro: ARB_REQ_TIMEOUT_EN builds the per-client
// starvation timers and the stall flags. Without it, stall is tied to zero.
module arb_req_frontend #(
  parameter int CNT_W = 4,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_req1,
  input  logic             in_req2,
  input  logic             in_req3,
  output logic             in_rdy1,
  output logic             in_rdy2,
  output logic             in_rdy3,
  input  logic             a1,
  input  logic             a2,
  input  logic             a3,
  output logic             r1,
  output logic             r2,
  output logic             r3,
  output logic [CNT_W-1:0] pend1,
  output logic [CNT_W-1:0] pend2,
  output logic [CNT_W-1:0] pend3,
  output logic [2:0]       ovf,
  output logic [2:0]       gerr,
  input  logic             flag_clr,
  output logic [2:0]       stall
);

  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PEND_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       w_req;
  logic [2:0]       w_gnt;
  logic [2:0]       w_zero;
  logic [2:0]       w_full;
  logic [2:0]       w_dec;
  logic [2:0]       w_ovf_set;
  logic [2:0]       w_gerr_set;
  logic [CNT_W-1:0] w_pend_nxt [3];
  logic [CNT_W-1:0] r_pend     [3];
  logic [2:0]       r_ovf;
  logic [2:0]       r_gerr;

  assign w_req = {in_req3, in_req2, in_req1};
  assign w_gnt = {a3, a2, a1};

  // Per-client next pending count and flag-set conditions.
  always_comb begin
    w_zero     = 3'b000;
    w_full     = 3'b000;
    w_dec      = 3'b000;
    w_ovf_set  = 3'b000;
    w_gerr_set = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_pend_nxt[i] = r_pend[i];
      w_zero[i]     = (r_pend[i] == PEND_ZERO);
      w_full[i]     = (r_pend[i] == PEND_MAX);
      // A grant only retires work when something is pending.
      w_dec[i]      = w_gnt[i] & ~w_zero[i];
      w_gerr_set[i] = w_gnt[i] & w_zero[i];
      case ({w_req[i], w_dec[i]})
        2'b10: begin
          if (w_full[i]) begin
            // Full and nothing retiring: drop the request.
            w_ovf_set[i] = 1'b1;
          end else begin
            w_pend_nxt[i] = r_pend[i] + PEND_ONE;
          end
        end
        2'b01:   w_pend_nxt[i] = r_pend[i] - PEND_ONE;
        default: w_pend_nxt[i] = r_pend[i];
      endcase
    end
  end

  // Pending counters and sticky flags; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        r_pend[i] <= PEND_ZERO;
      end
      r_ovf  <= 3'b000;
      r_gerr <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_pend[i] <= w_pend_nxt[i];
      end
      r_ovf  <= (flag_clr ? 3'b000 : r_ovf)  | w_ovf_set;
      r_gerr <= (flag_clr ? 3'b000 : r_gerr) | w_gerr_set;
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMR_MAX  = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMR_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMR_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] w_tmr_nxt [3];
  logic [TMO_W-1:0] r_tmr     [3];
  logic [2:0]       w_stall_set;
  logic [2:0]       r_stall;

  // Starvation timers: count cycles pending without a grant, saturating.
  always_comb begin
    w_stall_set = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (w_gnt[i] || w_zero[i]) begin
        w_tmr_nxt[i] = TMR_ZERO;
      end else if (r_tmr[i] != TMR_MAX) begin
        w_tmr_nxt[i] = r_tmr[i] + TMR_ONE;
      end else begin
        w_tmr_nxt[i] = r_tmr[i];
      end
      w_stall_set[i] = (w_tmr_nxt[i] == TMR_MAX);
    end
  end

  // Timer registers and sticky stall flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        r_tmr[i] <= TMR_ZERO;
      end
      r_stall <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_tmr[i] <= w_tmr_nxt[i];
      end
      r_stall <= (flag_clr ? 3'b000 : r_stall) | w_stall_set;
    end
  end

  assign stall = r_stall;
`else
  assign stall = 3'b000;
`endif

  // Outputs decode registered state only; there is no path from in_req or a.
  assign pend1   = r_pend[0];
  assign pend2   = r_pend[1];
  assign pend3   = r_pend[2];
  assign r1      = (r_pend[0] != PEND_ZERO);
  assign r2      = (r_pend[1] != PEND_ZERO);
  assign r3      = (r_pend[2] != PEND_ZERO);
  assign in_rdy1 = (r_pend[0] != PEND_MAX);
  assign in_rdy2 = (r_pend[1] != PEND_MAX);
  assign in_rdy3 = (r_pend[2] != PEND_MAX);
  assign ovf     = r_ovf;
  assign gerr    = r_gerr;

endmodule

// File: doc/arb_req_frontend.md
# arb_req_frontend

Request conditioning stage in front of the three-client round-robin arbiter (r1/r2/r3 → a1/a2/a3). Each client issues single-cycle request pulses. The block queues them as per-client pending counts and drives a level request r1..r3 into the arbiter while work is outstanding. It retires one pending request for every grant cycle (a1..a3 high) returned by the arbiter, and flags overflow, spurious grants and, optionally, starvation.

## Interface
- CNT_W, default 4: width of each pending counter. MAX = 2^CNT_W − 1 pending requests per client.
- TMO_W, default 8: width of the starvation timer. Used only when ARB_REQ_TIMEOUT_EN is defined.
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_req1, in_req2, in_req3  input  1 each  client request pulse; one request per high cycle.
- in_rdy1, in_rdy2, in_rdy3  output  1 each  client may issue; high when the pending count is below MAX.
- a1, a2, a3  input  1 each  grants from the arbiter; each high cycle retires one request.
- r1, r2, r3  output  1 each  request level to the arbiter; high when the pending count is not 0.
- pend1, pend2, pend3  output  CNT_W each  current pending count.
- ovf  output  3  sticky overflow, bit i−1 for client i.
- gerr  output  3  sticky spurious-grant flag, bit i−1 for client i.
- flag_clr  input  1  synchronous clear of ovf, gerr and stall.
- stall  output  3  sticky starvation flag. Tied to 0 when ARB_REQ_TIMEOUT_EN is not defined.

## Operation
- The three channels are independent and identical. Per channel i, with inc = in_req_i and dec = a_i && pend_i != 0:
  - inc && !dec: pend increments, provided pend < MAX.
  - dec && !inc: pend decrements.
  - inc && dec: pend is unchanged; the request is accepted even when pend == MAX.
  - neither: pend holds.
- Overflow: in_req_i while pend == MAX and a_i low → the request is dropped, pend stays MAX, ovf[i−1] sets.
- Spurious grant: a_i while pend == 0 → ignored (pend stays 0), gerr[i−1] sets.
  - If in_req_i is high in the same cycle, the request is still accepted (pend becomes 1).
- Output decode:
  - r_i = (pend_i != 0).
  - in_rdy_i = (pend_i != MAX).
  - Both are decoded from registered state only, with no combinational path from in_req or a to any output.
- Flags:
  - ovf, gerr and stall hold until flag_clr or reset.
  - When flag_clr and a set condition occur in the same cycle, set wins.
- Counter arithmetic is unsigned CNT_W-bit and never wraps. Both saturation guards are mandatory.

## Timing
- Reset (rstn low, asynchronous) forces:
  - pend1..3 = 0, r1..3 = 0, in_rdy1..3 = 1.
  - ovf = 0, gerr = 0, stall = 0, all timers = 0.
- Reset asserted mid-operation discards every pending request immediately. There is no drain.
- Latency in_req → r: 1 cycle. A pulse at edge N gives pend = 1 and r high after edge N.
- Latency a → r drop: 1 cycle when the last request retires.
- Back-to-back grants on consecutive cycles each retire one request.
- The arbiter's registered grant lags r by ≥1 cycle. That loop latency is the arbiter's; this block adds none beyond its output registers.

## Configuration
- ARB_REQ_TIMEOUT_EN defined: each channel has a TMO_W-bit timer.
  - Timer clears on any cycle with a_i high or pend_i == 0.
  - Otherwise the timer increments, saturating at 2^TMO_W − 1.
  - The timer reaching 2^TMO_W − 1 sets stall[i−1].
- ARB_REQ_TIMEOUT_EN undefined: no timers are built, stall is constant 3'b000, and flag_clr affects only ovf and gerr.

## Test plan
All scenarios use CNT_W = 2 (MAX = 3).
- Reset release, then in_req1 pulse → next cycle pend1 = 1, r1 = 1, in_rdy1 = 1. Then a1 for one cycle → pend1 = 0, r1 = 0.
- in_req2 for 4 consecutive cycles, no grant → pend2 = 3, in_rdy2 = 0, ovf = 3'b010. flag_clr → ovf = 0, pend2 stays 3.
- pend3 = 3, then in_req3 and a3 in the same cycle → pend3 stays 3, ovf[2] stays 0.
- a1 with pend1 = 0 → pend1 = 0, gerr = 3'b001. a1 and in_req1 together with pend1 = 0 → pend1 = 1, gerr[0] set.
- pend1 = 2, pend2 = 1, then rstn pulsed low between edges → immediately all pend = 0, r = 0, in_rdy = 3'b111, flags cleared.
- ARB_REQ_TIMEOUT_EN, TMO_W = 3: pend1 = 1 with no grant for 7 cycles → stall = 3'b001. A grant at cycle 5 instead keeps stall = 0.
